// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register responder.
package spi_reg_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      DATA = 2'd2
   } state_t;

   localparam int NREGS               = 32;
   localparam int ADDR_W              = 5;
   localparam int CMD_ADDR_MSB        = 7;
   localparam int CMD_ADDR_LSB        = 3;
   localparam int CMD_DIR_BIT         = 1;
   localparam int DEFAULT_STATUS_ADDR = 25;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with single-cycle rise/fall strobes on the synchronized level.
module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              prev;
   logic              level;

   assign level = chain[STAGES-1];

   // Chain resets low so a pin that is already low after reset produces no edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain <= '0;
         prev  <= 1'b0;
      end else begin
         chain <= (chain << 1) | STAGES'(d);
         prev  <= level;
      end
   end

   assign rise = level & ~prev;
   assign fall = ~level & prev;

endmodule

// File: rtl/spi_reg_responder.sv
// SPI mode-0 responder exposing a 32x8 register file, oversampled on clk_50.
//
// state | meaning
// IDLE  | waiting for ss_n fall
// CMD   | shifting in command byte, status byte shifting out
// DATA  | write commits or repeated reads of the latched address
module spi_reg_responder
   import spi_reg_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int STATUS_ADDR = DEFAULT_STATUS_ADDR
) (
   input  logic              clk_50,
   input  logic              reset_50,
   input  logic              sclk,
   input  logic              mosi,
   input  logic              ss_n,
   output logic              miso,
   output logic              miso_oe,
   input  logic              loc_we,
   input  logic [ADDR_W-1:0] loc_addr,
   input  logic [7:0]        loc_wdata,
   output logic [7:0]        loc_rdata,
   output logic              spi_wr_valid,
   output logic [ADDR_W-1:0] spi_wr_addr,
   output logic [7:0]        spi_wr_data
);

   localparam logic [ADDR_W-1:0] STATUS_IDX = ADDR_W'(STATUS_ADDR);

   logic                   sclk_rise, sclk_fall;
   logic                   ss_rise, ss_fall;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   mosi_s;

   state_t                 state;
   logic [2:0]             bit_cnt;
   logic [6:0]             shift_in;
   logic [7:0]             rx_byte;
   logic [7:0]             out_byte;
   logic [ADDR_W-1:0]      addr;
   logic                   dir;
   logic                   miso_q;
   logic [7:0]             regs [NREGS];

   sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
      .clk  (clk_50),
      .rst  (reset_50),
      .d    (sclk),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
      .clk  (clk_50),
      .rst  (reset_50),
      .d    (ss_n),
      .rise (ss_rise),
      .fall (ss_fall)
   );

   // Same depth as the sclk chain so mosi lines up with the detected rise.
   always_ff @(posedge clk_50 or posedge reset_50) begin
      if (reset_50) mosi_sync <= '0;
      else          mosi_sync <= (mosi_sync << 1) | SYNC_STAGES'(mosi);
   end

   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign rx_byte   = {shift_in, mosi_s};
   assign loc_rdata = regs[loc_addr];
   assign miso      = miso_q & miso_oe;

   always_ff @(posedge clk_50 or posedge reset_50) begin
      if (reset_50) begin
         state        <= IDLE;
         bit_cnt      <= '0;
         shift_in     <= '0;
         out_byte     <= '0;
         addr         <= '0;
         dir          <= 1'b0;
         miso_q       <= 1'b0;
         miso_oe      <= 1'b0;
         spi_wr_valid <= 1'b0;
         spi_wr_addr  <= '0;
         spi_wr_data  <= '0;
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         spi_wr_valid <= 1'b0;
         // Local write first so a same-address SPI commit below overrides it.
         if (loc_we) regs[loc_addr] <= loc_wdata;

         // Enable only opens on a fall seen from IDLE, so a select held low
         // through reset stays undriven until the master reasserts it.
         if (ss_rise)                      miso_oe <= 1'b0;
         else if (ss_fall && state == IDLE) miso_oe <= 1'b1;

         if (ss_rise) begin
            state   <= IDLE;
            bit_cnt <= '0;
            miso_q  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (ss_fall) begin
                     out_byte <= regs[STATUS_IDX];
                     miso_q   <= regs[STATUS_IDX][7];
                     bit_cnt  <= '0;
                     state    <= CMD;
                  end
               end
               CMD, DATA: begin
                  if (sclk_rise) begin
                     shift_in <= rx_byte[6:0];
                     bit_cnt  <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        if (state == CMD) begin
                           addr  <= rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB];
                           dir   <= rx_byte[CMD_DIR_BIT];
                           state <= DATA;
                           if (!rx_byte[CMD_DIR_BIT])
                              out_byte <= regs[rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB]];
                        end else if (dir) begin
                           regs[addr]   <= rx_byte;
                           spi_wr_valid <= 1'b1;
                           spi_wr_addr  <= addr;
                           spi_wr_data  <= rx_byte;
                        end else begin
                           out_byte <= regs[addr];
                        end
                     end
                  end else if (sclk_fall) begin
                     // bit_cnt already counts the rises, so it selects the next bit out.
                     miso_q <= out_byte[3'd7 - bit_cnt];
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_reg_responder.sv
// Self-checking bench for spi_reg_responder: vector table plus hand-built corner sequences.
module tb_spi_reg_responder;

   typedef struct {
      logic       pre_we;
      logic [4:0] pre_addr;
      logic [7:0] pre_data;
      logic [7:0] cmd;
      int         nb;
      logic [7:0] d0;
      logic [7:0] d1;
      logic [7:0] e_stat;
      logic [7:0] e_r0;
      logic [7:0] e_r1;
      logic       conf;
      logic [4:0] chk_addr;
      logic [7:0] chk_val;
   } vec_t;

   logic       clk_50 = 1'b0;
   logic       reset_50, sclk, mosi, ss_n, miso, miso_oe, loc_we;
   logic [4:0] loc_addr;
   logic [7:0] loc_wdata, loc_rdata;
   logic       spi_wr_valid;
   logic [4:0] spi_wr_addr;
   logic [7:0] spi_wr_data;

   int          checks = 0;
   int          fails  = 0;
   logic [7:0]  miso_q[$];
   logic [12:0] wr_q[$];
   logic [12:0] wr_exp;
   vec_t        vecs[5];
   logic [7:0]  rx;
   logic        rb;
   logic [7:0]  part;

   always #10 clk_50 = ~clk_50;

   spi_reg_responder dut (
      .clk_50       (clk_50),
      .reset_50     (reset_50),
      .sclk         (sclk),
      .mosi         (mosi),
      .ss_n         (ss_n),
      .miso         (miso),
      .miso_oe      (miso_oe),
      .loc_we       (loc_we),
      .loc_addr     (loc_addr),
      .loc_wdata    (loc_wdata),
      .loc_rdata    (loc_rdata),
      .spi_wr_valid (spi_wr_valid),
      .spi_wr_addr  (spi_wr_addr),
      .spi_wr_data  (spi_wr_data)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_50);
      #1;
   endtask

   task automatic loc_write(input logic [4:0] a, input logic [7:0] d);
      loc_addr = a; loc_wdata = d; loc_we = 1'b1;
      tick(1);
      loc_we = 1'b0;
   endtask

   task automatic loc_check(input string name, input logic [4:0] a, input logic [7:0] e);
      loc_addr = a;
      #1;
      check(name, loc_rdata, e);
   endtask

   task automatic miso_pop(input string name, input logic [7:0] got);
      if (miso_q.size() == 0) begin
         checks++; fails++;
         $display("FAIL %s: got 0x%0h, expected no byte queued", name, got);
      end else begin
         check(name, got, miso_q.pop_front());
      end
   endtask

   // One SCLK period; conf drives a local write to reg7 onto the commit edge.
   task automatic spi_bit(input logic b, input logic conf, output logic r);
      mosi = b;
      tick(5);
      r = miso;
      sclk = 1'b1;
      if (conf) begin
         tick(2);
         loc_addr = 5'd7; loc_wdata = 8'h99; loc_we = 1'b1;
         tick(1);
         loc_we = 1'b0;
         tick(2);
      end else begin
         tick(5);
      end
      sclk = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] tx, input logic conf, output logic [7:0] r);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(tx[i], conf && (i == 0), b);
         r[i] = b;
      end
   endtask

   task automatic xfer(input vec_t v);
      logic [7:0] r, d;
      if (v.pre_we) loc_write(v.pre_addr, v.pre_data);
      miso_q.push_back(v.e_stat);
      ss_n = 1'b0;
      tick(2);
      spi_byte(v.cmd, 1'b0, r);
      miso_pop("status_byte", r);
      for (int j = 0; j < v.nb; j++) begin
         d = (j == 0) ? v.d0 : v.d1;
         if (v.cmd[1]) begin
            wr_q.push_back({v.cmd[7:3], d});
            spi_byte(d, v.conf && (j == v.nb - 1), r);
         end else begin
            miso_q.push_back((j == 0) ? v.e_r0 : v.e_r1);
            spi_byte(d, 1'b0, r);
            miso_pop("read_byte", r);
         end
      end
      check("miso_oe_active", miso_oe, 1);
      tick(5);
      ss_n = 1'b1;
      tick(5);
      check("miso_oe_idle", miso_oe, 0);
      loc_check("reg_after_xfer", v.chk_addr, v.chk_val);
   endtask

   always @(negedge clk_50) begin
      if (!reset_50 && spi_wr_valid) begin
         if (wr_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_commit: got addr %0d data 0x%0h, expected no commit",
                     spi_wr_addr, spi_wr_data);
         end else begin
            wr_exp = wr_q.pop_front();
            check("commit_addr", spi_wr_addr, wr_exp[12:8]);
            check("commit_data", spi_wr_data, wr_exp[7:0]);
         end
      end
   end

   initial begin
      reset_50 = 1'b1; sclk = 1'b0; mosi = 1'b0; ss_n = 1'b1;
      loc_we = 1'b0; loc_addr = 5'd25; loc_wdata = 8'h00;

      vecs[0] = '{1'b1, 5'd4,  8'h55, 8'h20, 2, 8'h00, 8'h00, 8'h00, 8'h55, 8'h55, 1'b0, 5'd4,  8'h55};
      vecs[1] = '{1'b0, 5'd0,  8'h00, 8'h0A, 2, 8'h3C, 8'h7E, 8'h00, 8'h00, 8'h00, 1'b0, 5'd1,  8'h7E};
      vecs[2] = '{1'b1, 5'd25, 8'hA5, 8'hC8, 1, 8'h00, 8'h00, 8'hA5, 8'hA5, 8'h00, 1'b0, 5'd25, 8'hA5};
      vecs[3] = '{1'b0, 5'd0,  8'h00, 8'h08, 1, 8'hFF, 8'h00, 8'hA5, 8'h7E, 8'h00, 1'b0, 5'd1,  8'h7E};
      vecs[4] = '{1'b0, 5'd0,  8'h00, 8'h3A, 1, 8'h42, 8'h00, 8'hA5, 8'h00, 8'h00, 1'b0, 5'd7,  8'h42};

      tick(1);
      check("rst_miso", miso, 0);
      check("rst_miso_oe", miso_oe, 0);
      check("rst_wr_valid", spi_wr_valid, 0);
      check("rst_wr_addr", spi_wr_addr, 0);
      check("rst_wr_data", spi_wr_data, 0);
      loc_check("rst_reg25", 5'd25, 8'h00);
      reset_50 = 1'b0;
      tick(5);

      for (int k = 0; k < 5; k++) xfer(vecs[k]);

      // Abort: write command then a partial data byte.
      miso_q.push_back(8'hA5);
      ss_n = 1'b0;
      tick(2);
      spi_byte(8'h12, 1'b0, rx);
      miso_pop("abort_status", rx);
      part = 8'hF8;
      for (int i = 7; i >= 3; i--) spi_bit(part[i], 1'b0, rb);
      tick(5);
      ss_n = 1'b1;
      tick(5);
      loc_check("abort_reg2", 5'd2, 8'h00);
      xfer('{1'b0, 5'd0, 8'h00, 8'h10, 1, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h00, 1'b0, 5'd2, 8'h00});

      // SPI commit and local write land on reg7 in the same cycle.
      xfer('{1'b0, 5'd0, 8'h00, 8'h3A, 1, 8'h11, 8'h00, 8'hA5, 8'h00, 8'h00, 1'b1, 5'd7, 8'h11});

      // Reset in the middle of a data byte.
      miso_q.push_back(8'hA5);
      ss_n = 1'b0;
      tick(2);
      spi_byte(8'h2A, 1'b0, rx);
      miso_pop("midrst_status", rx);
      part = 8'h66;
      for (int i = 7; i >= 4; i--) spi_bit(part[i], 1'b0, rb);
      reset_50 = 1'b1;
      #1;
      check("midrst_miso", miso, 0);
      check("midrst_miso_oe", miso_oe, 0);
      check("midrst_wr_valid", spi_wr_valid, 0);
      check("midrst_wr_addr", spi_wr_addr, 0);
      check("midrst_wr_data", spi_wr_data, 0);
      tick(1);
      reset_50 = 1'b0;
      tick(4);
      check("midrst_oe_held_low", miso_oe, 0);
      loc_check("midrst_reg25", 5'd25, 8'h00);
      loc_check("midrst_reg1", 5'd1, 8'h00);
      loc_check("midrst_reg7", 5'd7, 8'h00);
      ss_n = 1'b1;
      tick(5);
      xfer('{1'b0, 5'd0, 8'h00, 8'h2A, 1, 8'h66, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 5'd5, 8'h66});

      tick(5);
      check("commits_outstanding", wr_q.size(), 0);
      check("miso_bytes_outstanding", miso_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/spi_reg_responder.md
# spi_reg_responder

SPI mode-0 responder implementing the MAX3421E-style register protocol on the far end of the SoC's `spi0` master. It gives fabric logic a 32×8 register file that the Nios II USB driver can read and write over `spi0_MOSI/MISO/SCLK/SS_n`. It is also used as a bench/board stand-in for the USB host chip. All SPI pins are oversampled on the 50 MHz system clock; there is no SCLK clock domain.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on `sclk`, `mosi`, `ss_n`.
- `STATUS_ADDR`, default 25: register returned on MISO during the command byte.
- `clk_50`  in  1  system clock, 50 MHz.
- `reset_50`  in  1  reset; one clock, asynchronous, active-high.
- `sclk`  in  1  SPI clock from master, idle low.
- `mosi`  in  1  master-out data.
- `ss_n`  in  1  slave select, active low.
- `miso`  out  1  slave-out data; driven only while `miso_oe`.
- `miso_oe`  out  1  high while synchronized `ss_n` is low.
- `loc_we`  in  1  local register write strobe.
- `loc_addr`  in  5  local register address, for write and read.
- `loc_wdata`  in  8  local write data.
- `loc_rdata`  out  8  combinational read of `regs[loc_addr]`.
- `spi_wr_valid`  out  1  one-cycle pulse when an SPI write commits.
- `spi_wr_addr`  out  5  address of committed SPI write.
- `spi_wr_data`  out  8  data of committed SPI write.

## Operation
- **Sampling:** `sclk`, `mosi`, `ss_n` pass through `SYNC_STAGES` flops. Edges are detected on synchronized `sclk`/`ss_n`.
- **Mode 0:** MOSI is sampled on the detected SCLK rise. MISO advances on the detected SCLK fall. Bytes are MSB first.
- **State machine:**
  - `IDLE`: on `ss_n` fall, load the shift-out register with `regs[STATUS_ADDR]`, clear the bit counter, go to `CMD`.
  - `CMD`: shift in 8 bits. On the 8th rise, latch `addr=cmd[7:3]`, `dir=cmd[1]` (1 = write), ignore `cmd[0]`. For a read, load the shift-out register with `regs[addr]` for the following fall. Go to `DATA`.
  - `DATA`:
    - Write: on each 8th rise, commit `regs[addr]` ← byte and pulse `spi_wr_valid`.
    - Read: reload `regs[addr]` after every byte. This provides repeated reads of the same address.
    - There is no address auto-increment.
  - Any state: `ss_n` rise → `IDLE`. A partial byte is discarded and no commit occurs.
- **Write conflict:** if an SPI commit and `loc_we` hit the same address in the same cycle, the SPI write wins. Different addresses both commit.
- **Read snapshot:** read data is captured at load time. Later local writes do not alter a byte already being shifted.
- **Reset values:** all registers 0x00; state `IDLE`; `miso` 0, `miso_oe` 0, `spi_wr_valid` 0, `spi_wr_addr` 0, `spi_wr_data` 0; bit counter 0.
- **Reset mid-transfer:** the FSM returns to `IDLE`. The transfer resumes only after a fresh `ss_n` fall.

## Timing
- **Edge detection latency:** a pin edge is detected `SYNC_STAGES+1` cycles after it reaches the pin.
- **SCLK limits:** SCLK high and low times are each ≥ 4 `clk_50` cycles, so SCLK ≤ 6.25 MHz. `ss_n` fall to first SCLK rise ≥ 4 cycles.
- **First MISO bit:** the MSB of the status byte is on `miso` 1 cycle after the detected `ss_n` fall.
- **Later MISO bits:** each subsequent bit is valid 1 cycle after the detected SCLK fall.
- **Write commit:** the register update and the `spi_wr_valid`/addr/data outputs occur 1 cycle after the detected 8th rise of the byte. The pulse lasts exactly 1 cycle.
- **Local write:** `loc_we` writes on the clock edge. `loc_rdata` reflects the new value in the next cycle.
- **`miso_oe`:** follows synchronized `ss_n` with 1 cycle of register delay.

## Structure
- **Package `spi_reg_pkg`:**
  - state enum `IDLE`/`CMD`/`DATA`
  - constants `CMD_ADDR_MSB=7`, `CMD_ADDR_LSB=3`, `CMD_DIR_BIT=1`
  - `NREGS=32`
  - default `STATUS_ADDR`
- **Sub-module `sync_edge`:** `SYNC_STAGES`-deep synchronizer plus rise/fall detector. Instantiated for `sclk` and `ss_n`. `mosi` uses a plain synchronizer chain, kept aligned with `sclk` depth.
- **Top level:** the FSM, shift registers, bit counter and register file stay in the top level.

## Test plan
- **Status byte:** preload reg25=0xA5 locally; SPI transfer cmd 0xC8 (addr25, read) then a dummy byte → MISO bytes 0xA5, 0xA5.
- **Multi-byte write:** cmd 0x0A (addr1, write), data 0x3C, 0x7E → two `spi_wr_valid` pulses (addr 1, data 0x3C then 0x7E); `loc_rdata`@1 = 0x7E.
- **Read back:** local write reg4=0x55; cmd 0x20 (addr4, read) + 2 bytes → MISO 0x00 (status, reg25 = 0), then 0x55, 0x55.
- **Abort:** cmd 0x12 (addr2, write), 5 data bits, then `ss_n` high → no pulse; reg2 unchanged; next transfer starts in `CMD` correctly.
- **Same-cycle conflict:** SPI commit of 0x11 to addr7 coincident with `loc_we` of 0x99 to addr7 → reg7=0x11.
- **Reset mid-transfer:** assert `reset_50` during a data byte → all outputs 0, regs 0x00; a subsequent full write transfer commits normally.
